// File: rtl/mem_dma_arbiter.sv
// Single memory port shared by the CPU, an OAM-DMA page copier and a debug port.
// Debug wins in IDLE; a CPU write to DMA_REG_ADDR stalls the CPU while one page is copied to OAM.
module mem_dma_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
  parameter int DMA_LEN = 256,
  parameter int OAM_AW = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [OAM_AW-1:0]     oam_base,
  output logic [OAM_AW-1:0]     oam_addr,
  output logic                  oam_we,
  output logic [DATA_WIDTH-1:0] oam_wdata,
  output logic                  dma_busy,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic                  dbg_we,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid
);

  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] page_reg, page_next;
  logic [OAM_AW-1:0]     oam_ptr_reg, oam_ptr_next;
  logic [OAM_AW-1:0]     index_reg, index_next;
  logic                  dbg_rvalid_reg, dbg_rvalid_next;
  logic                  dma_trigger;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      page_reg       <= '0;
      oam_ptr_reg    <= '0;
      index_reg      <= '0;
      dbg_rvalid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      page_reg       <= page_next;
      oam_ptr_reg    <= oam_ptr_next;
      index_reg      <= index_next;
      dbg_rvalid_reg <= dbg_rvalid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    page_next       = page_reg;
    oam_ptr_next    = oam_ptr_reg;
    index_next      = index_reg;
    dbg_rvalid_next = 1'b0;
    cpu_rdy         = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_wdata       = '0;
    oam_addr        = '0;
    oam_we          = 1'b0;
    oam_wdata       = '0;
    dma_busy        = 1'b0;
    dbg_gnt         = 1'b0;
    dma_trigger     = cpu_we && (cpu_addr == DMA_REG_ADDR);

    // The memory mux is combinational, so hold it at its quiet values while reset is asserted.
    if (!reset_n) begin
      cpu_rdy = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dbg_req) begin
            mem_addr        = dbg_addr;
            mem_we          = dbg_we;
            mem_wdata       = dbg_wdata;
            dbg_gnt         = 1'b1;
            dbg_rvalid_next = !dbg_we;
          end else begin
            cpu_rdy   = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (dma_trigger) begin
              page_next    = cpu_wdata;
              oam_ptr_next = oam_base;
              index_next   = '0;
              state_next   = ALIGN;
            end else begin
              mem_we = cpu_we;
            end
          end
        end
        ALIGN: begin
          dma_busy   = 1'b1;
          state_next = RD;
        end
        RD: begin
          dma_busy   = 1'b1;
          mem_addr   = ADDR_WIDTH'({page_reg, index_reg});
          state_next = WR;
        end
        WR: begin
          dma_busy  = 1'b1;
          mem_addr  = ADDR_WIDTH'({page_reg, index_reg});
          oam_we    = 1'b1;
          oam_addr  = oam_ptr_reg + index_reg;
          oam_wdata = mem_rdata;
          if (index_reg == OAM_AW'(DMA_LEN - 1)) begin
            state_next = IDLE;
          end else begin
            index_next = index_reg + 1'b1;
            state_next = RD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign dbg_rvalid = dbg_rvalid_reg;

endmodule

// File: doc/mem_dma_arbiter.md
Name: mem_dma_arbiter

Overview:
- Owns the single system memory port and shares it between three requesters: the CPU, an internal OAM-DMA sequencer, and a bench/debug port.
- A CPU write to the DMA register address stalls the CPU (ready low) while the sequencer copies one 256-byte page from memory into OAM.
- The debug port is used by the bench for mid-simulation peeks and pokes.
- Sits between the CPU core, the memory array and the PPU OAM.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, data width (REG_WIDTH).
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- DMA_LEN, 256, bytes per DMA transfer; must be ≤ 2^OAM_AW.
- OAM_AW, 8, OAM address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdy  out  1  high when the CPU access is serviced this cycle; CPU holds its request while low
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, 1-cycle synchronous latency
- oam_base  in  OAM_AW  current OAMADDR value, sampled at DMA start
- oam_addr  out  OAM_AW  OAM write address
- oam_we  out  1  OAM write strobe
- oam_wdata  out  DATA_WIDTH  OAM write data
- dma_busy  out  1  high while a DMA is in progress
- dbg_req  in  1  debug access request
- dbg_addr  in  ADDR_WIDTH  debug address
- dbg_we  in  1  debug write enable
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  mem_rdata holds debug read data (1 cycle after a read grant)

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - cpu_rdy=1; mem_we=0; mem_addr=0; mem_wdata=0.
  - oam_we=0; oam_addr=0; oam_wdata=0.
  - dma_busy=0; dbg_gnt=0; dbg_rvalid=0; index counter=0; page=0.
  - Reset mid-DMA aborts the transfer; no further OAM writes occur after release.
- States: IDLE, ALIGN, RD, WR.
- IDLE, no dbg_req: mem_* driven combinationally from cpu_*, and cpu_rdy=1.
- IDLE, dbg_req=1:
  - Debug has priority: mem_* come from dbg_*, dbg_gnt=1, cpu_rdy=0 (CPU retries).
  - dbg_rvalid=1 on the next cycle iff the granted access was a read.
- DMA trigger: in IDLE with no dbg_req, cpu_we=1 and cpu_addr==DMA_REG_ADDR.
  - That write is acknowledged (cpu_rdy=1) but NOT forwarded to memory (mem_we=0).
  - Latch page=cpu_wdata and oam_ptr=oam_base; clear index; go to ALIGN.
- ALIGN: one dead cycle; cpu_rdy=0, dma_busy=1, mem_we=0.
- RD: mem_addr={page, index[7:0]}, mem_we=0; next state WR.
- WR:
  - oam_we=1, oam_addr=oam_ptr+index (mod 2^OAM_AW, wraps), oam_wdata=mem_rdata.
  - If index==DMA_LEN-1, go to IDLE; otherwise index++ and go to RD.
- During ALIGN/RD/WR: cpu_rdy=0, dma_busy=1, dbg_gnt=0. CPU and debug inputs are ignored and must be held by their requesters.
- Total CPU stall is exactly 1+2*DMA_LEN cycles (513 at defaults), counted from the cycle after the trigger.
- cpu_rdy=1 and dma_busy=0 in the first IDLE cycle after the final WR.
- A pending dbg_req is granted in that first IDLE cycle, ahead of the CPU.
- oam_we is asserted only in WR. Exactly DMA_LEN OAM writes occur per uninterrupted DMA.
- A CPU read of DMA_REG_ADDR is a normal memory read and does not trigger DMA.

Test Plan:
- Preload mem[0x0200+i]=i^8'hA5; oam_base=0; CPU writes 8'h02 to 0x4014 → cpu_rdy low for exactly 513 cycles; 256 oam_we pulses; OAM[i]=i^8'hA5; mem[0x4014] unchanged.
- oam_base=8'hF0, page 0x03 → first OAM write goes to addr 0xF0, 17th write to 0x00 (wrap); final write to 0xEF.
- dbg_req held during a DMA → dbg_gnt=0 throughout; dbg_gnt=1 in the first post-DMA cycle with cpu_rdy=0; CPU serviced the following cycle.
- Debug write 0x5A to 0x0010, then debug read 0x0010 → dbg_rvalid=1 one cycle after the read grant, with mem_rdata=0x5A.
- reset_n pulsed low at DMA byte 100 → all outputs return to reset values immediately; after release, no oam_we; CPU access serviced with cpu_rdy=1.
- Back-to-back: CPU triggers a second DMA (page 0x04) on the first cycle after the first completes → second stall of 513 cycles; OAM holds page 0x04 data.
